// File: rtl/f1_sequencer.sv
// F1 start-light reaction timer: five lights step on, a random delay runs,
// then the cycles until the reaction press are measured. Early presses are faults.
`timescale 1ns/1ps
module f1_sequencer #(
  parameter int TICK_N = 25000000,
  parameter int BIT_SZ = 14,
  parameter int CNT_SZ = 16
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              start,
  input  logic              react,
  input  logic              time_out,
  output logic              trigger,
  output logic [BIT_SZ-1:0] N,
  output logic [4:0]        ledr,
  output logic [CNT_SZ-1:0] react_time,
  output logic              valid,
  output logic              false_start,
  output logic [2:0]        state
);

  localparam int TW = (TICK_N > 1) ? $clog2(TICK_N) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_N - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LIGHTS  = 3'd1,
    ARM     = 3'd2,
    MEASURE = 3'd3,
    DONE    = 3'd4,
    FAULT   = 3'd5
  } state_t;

  state_t            state_reg;
  logic [13:0]       lfsr_reg;
  logic [TW-1:0]     tick_reg;
  logic [CNT_SZ-1:0] rcnt_reg;
  // Set once start has been seen low; a button held through reset release
  // therefore cannot produce a start event until it is released and pressed.
  logic              start_low_reg;

  logic              start_evt;
  logic              lfsr_fb;
  logic [BIT_SZ-1:0] lfsr_n;

  assign start_evt = start & start_low_reg;
  assign lfsr_fb   = lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[11] ^ lfsr_reg[1];
  assign lfsr_n    = BIT_SZ'(lfsr_reg);
  assign state     = state_reg;

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      lfsr_reg      <= 14'h0001;
      tick_reg      <= '0;
      rcnt_reg      <= '0;
      start_low_reg <= 1'b0;
      trigger       <= 1'b0;
      N             <= BIT_SZ'(1);
      ledr          <= 5'b00000;
      react_time    <= '0;
      valid         <= 1'b0;
      false_start   <= 1'b0;
    end else begin
      lfsr_reg      <= {lfsr_reg[12:0], lfsr_fb};
      start_low_reg <= ~start;
      case (state_reg)
        IDLE, DONE, FAULT: begin
          if (start_evt) begin
            state_reg   <= LIGHTS;
            ledr        <= 5'b00001;
            tick_reg    <= '0;
            valid       <= 1'b0;
            false_start <= 1'b0;
          end
        end
        LIGHTS, ARM: begin
          if (react) begin
            // An early press wins over a coincident time_out.
            state_reg   <= FAULT;
            false_start <= 1'b1;
            trigger     <= 1'b0;
            ledr        <= 5'b10101;
            valid       <= 1'b0;
          end else if (state_reg == LIGHTS) begin
            if (tick_reg == TICK_LAST) begin
              tick_reg <= '0;
              if (ledr == 5'b11111) begin
                state_reg <= ARM;
                N         <= lfsr_n;
                trigger   <= 1'b1;
              end else begin
                ledr <= {ledr[3:0], 1'b1};
              end
            end else begin
              tick_reg <= tick_reg + TW'(1);
            end
          end else if (time_out) begin
            state_reg <= MEASURE;
            trigger   <= 1'b0;
            ledr      <= 5'b00000;
            rcnt_reg  <= '0;
          end
        end
        MEASURE: begin
          if (react) begin
            react_time <= rcnt_reg;
            valid      <= 1'b1;
            state_reg  <= DONE;
          end else if (rcnt_reg != '1) begin
            rcnt_reg <= rcnt_reg + CNT_SZ'(1);
          end
        end
        default: begin
          state_reg   <= IDLE;
          trigger     <= 1'b0;
          N           <= BIT_SZ'(1);
          ledr        <= 5'b00000;
          react_time  <= '0;
          valid       <= 1'b0;
          false_start <= 1'b0;
        end
      endcase
    end
  end

endmodule
